// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side buses of the instruction cache
interface icache_if;
  // datapath fetch port
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  // memory controller instruction port
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // performance counters
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // the cache itself
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  // the surrounding datapath and memory controller
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-block instruction cache
module icache #(
  parameter int SETS = 16
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t state_q, state_d;

  // frame storage
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // address of the outstanding fill, word aligned
  logic [31:0] miss_addr_q, miss_addr_d;

  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // fetch address decomposition
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic hit;
  logic fill;

  // FSM outputs
  logic        ihit_o;
  logic [31:0] imemload_o;
  logic        iren_o;
  logic [31:0] iaddr_o;

  assign fetch_idx = bus.imemaddr[IDX_W+1:2];
  assign fetch_tag = bus.imemaddr[31:IDX_W+2];
  assign miss_idx  = miss_addr_q[IDX_W+1:2];
  assign miss_tag  = miss_addr_q[31:IDX_W+2];

  // hits are only reported from IDLE so a redirected fetch during a fill never
  // sees a stale frame
  assign hit = (state_q == IDLE) && bus.imemREN && valid_q[fetch_idx]
               && (tag_q[fetch_idx] == fetch_tag);

  // fill data is accepted in the MISS cycle where the controller drops iwait
  assign fill = (state_q == MISS) && !bus.iwait;

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (!bus.iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs toward the datapath and the memory controller
  always_comb begin
    ihit_o     = 1'b0;
    imemload_o = 32'h0;
    iren_o     = 1'b0;
    iaddr_o    = 32'h0;
    case (state_q)
      IDLE: begin
        ihit_o     = hit;
        imemload_o = hit ? data_q[fetch_idx] : 32'h0;
      end
      MISS: begin
        iren_o  = 1'b1;
        iaddr_o = miss_addr_q;
      end
      default: begin
        iren_o = 1'b0;
      end
    endcase
  end

  assign bus.ihit     = ihit_o;
  assign bus.imemload = imemload_o;
  assign bus.iREN     = iren_o;
  assign bus.iaddr    = iaddr_o;

  // miss address latched on the IDLE->MISS transition and held through the fill
  always_comb begin
    miss_addr_d = miss_addr_q;
    if ((state_q == IDLE) && bus.imemREN && !hit) begin
      miss_addr_d = {bus.imemaddr[31:2], 2'b00};
    end
  end

  // saturating performance counters
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (fill && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // control registers: miss address and counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr_q  <= 32'h0;
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // valid bits are the only frame state that needs a reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[miss_idx] <= 1'b1;
    end
  end

  // tag and data written on fill; a conflicting fill simply overwrites
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.iload;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
  localparam int MEM_LAT = 3;

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   mem_cnt;

  icache_if bus ();

  icache #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // instruction memory contents: unique per address, 0x0 holds 0x2001_0005
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2001_0005 ^ (a << 14);
  endfunction

  // memory controller: holds iwait for MEM_LAT cycles of each request
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_cnt <= 0;
    end else if (bus.iREN && (mem_cnt < MEM_LAT)) begin
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  assign bus.iwait = !(bus.iREN && (mem_cnt >= MEM_LAT));
  assign bus.iload = bus.iREN ? mem_word(bus.iaddr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // fetch until hit; counts iREN cycles and leaves imemREN low before the next edge
  task automatic fetch(input logic [31:0] a, input int exp_ren, input string tag);
    int ren;
    bit got;
    ren = 0;
    got = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.ihit === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.iREN === 1'b1) ren++;
        tick();
      end
    end
    chk({tag, " hit"}, {31'h0, got}, 32'h1);
    chk({tag, " iren_cycles"}, ren, exp_ren);
    chk({tag, " imemload"}, bus.imemload, mem_word(a));
    bus.imemREN = 1'b0;
  endtask

  initial begin
    int guard;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;

    // reset state
    tick();
    tick();
    chk("rst ihit", bus.ihit, 32'h0);
    chk("rst imemload", bus.imemload, 32'h0);
    chk("rst iren", bus.iREN, 32'h0);
    chk("rst iaddr", bus.iaddr, 32'h0);
    chk("rst hit_count", bus.hit_count, 32'h0);
    chk("rst miss_count", bus.miss_count, 32'h0);
    nRST = 1'b1;
    tick();

    // 1: cold miss on 0x0, three wait cycles plus the fill cycle
    fetch(32'h0, 4, "t1 0x0");
    chk("t1 imemload const", bus.imemload, 32'h2001_0005);
    chk("t1 miss_count", bus.miss_count, 32'd1);
    chk("t1 hit_count", bus.hit_count, 32'd0);

    // 2: five back-to-back hits on 0x0
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2 ihit", bus.ihit, 32'h1);
      chk("t2 iren", bus.iREN, 32'h0);
      tick();
    end
    bus.imemREN = 1'b0;
    chk("t2 hit_count", bus.hit_count, 32'd5);
    tick();
    chk("t2 idle no count", bus.hit_count, 32'd5);
    chk("t2 idle ihit", bus.ihit, 32'h0);

    // 3: conflict at index 0 evicts 0x0
    fetch(32'h40, 4, "t3 0x40");
    chk("t3 miss_count a", bus.miss_count, 32'd2);
    tick();
    fetch(32'h0, 4, "t3 0x0 evicted");
    chk("t3 miss_count b", bus.miss_count, 32'd3);
    tick();

    // 4: redirect mid-fill; latched fill still completes
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h8;
    #1;
    chk("t4 first ihit", bus.ihit, 32'h0);
    tick();
    chk("t4 iren", bus.iREN, 32'h1);
    chk("t4 iaddr a", bus.iaddr, 32'h8);
    bus.imemaddr = 32'h100;
    #1;
    chk("t4 redirect ihit", bus.ihit, 32'h0);
    chk("t4 iaddr b", bus.iaddr, 32'h8);
    tick();
    chk("t4 iaddr c", bus.iaddr, 32'h8);
    guard = 0;
    while ((bus.iREN === 1'b1) && (guard < 20)) begin
      chk("t4 no hit in miss", bus.ihit, 32'h0);
      tick();
      guard++;
    end
    chk("t4 fill done", bus.iREN, 32'h0);
    chk("t4 miss_count a", bus.miss_count, 32'd4);
    fetch(32'h100, 4, "t4 0x100");
    chk("t4 miss_count b", bus.miss_count, 32'd5);
    tick();
    fetch(32'h8, 0, "t4 0x8 hit");
    tick();

    // 5: async reset in the middle of a fill
    fetch(32'h0, 4, "t5 refill 0x0");
    tick();
    fetch(32'h0, 0, "t5 0x0 hit");
    tick();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h20;
    #1;
    chk("t5 miss ihit", bus.ihit, 32'h0);
    tick();
    chk("t5 iren before rst", bus.iREN, 32'h1);
    nRST = 1'b0;
    #1;
    chk("t5 iren in rst", bus.iREN, 32'h0);
    chk("t5 iaddr in rst", bus.iaddr, 32'h0);
    chk("t5 miss_count in rst", bus.miss_count, 32'h0);
    chk("t5 hit_count in rst", bus.hit_count, 32'h0);
    bus.imemREN = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
    chk("t5 counters after rst", bus.miss_count | bus.hit_count, 32'h0);
    fetch(32'h0, 4, "t5 0x0 invalidated");
    chk("t5 miss_count", bus.miss_count, 32'd1);
    tick();

    // 6: fill all sixteen frames, then hit all of them
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      fetch(i * 4, 4, "t6 pass1");
      tick();
    end
    chk("t6 miss_count pass1", bus.miss_count, 32'd16);
    chk("t6 hit_count pass1", bus.hit_count, 32'd0);
    bus.imemREN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.imemaddr = i * 4;
      #1;
      chk("t6 pass2 ihit", bus.ihit, 32'h1);
      chk("t6 pass2 imemload", bus.imemload, mem_word(i * 4));
      tick();
    end
    bus.imemREN = 1'b0;
    #1;
    chk("t6 hit_count pass2", bus.hit_count, 32'd16);
    chk("t6 miss_count pass2", bus.miss_count, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
